// File: rtl/video_stream_tx_if.sv
// Pixel stream in, timed video out: the handshake and output bundle of video_stream_tx.
interface video_stream_tx_if;
  logic       enable;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic       vs;
  logic       de;
  logic [7:0] data;
  logic       frame_done;
  logic       underflow;

  modport master (
    input  enable, s_valid, s_data,
    output s_ready, vs, de, data, frame_done, underflow
  );

  modport slave (
    output enable, s_valid, s_data,
    input  s_ready, vs, de, data, frame_done, underflow
  );
endinterface

// File: rtl/video_stream_tx.sv
// Raster timing generator that pulls one pixel per active cycle and emits vs/de/data one cycle later.
// No buffering: s_ready is the active window itself, so a late pixel becomes 8'h00 and sets sticky underflow.
module video_stream_tx #(
  parameter int W        = 640,
  parameter int H        = 480,
  parameter int HBLANK   = 160,
  parameter int VS_LINES = 2,
  parameter int VBP      = 33,
  parameter int VFP      = 10
) (
  input logic               clk,
  input logic               rst,
  video_stream_tx_if.master bus
);

  localparam int HTOT = W + HBLANK;
  localparam int VTOT = VS_LINES + VBP + H + VFP;

  localparam logic [11:0] H_LAST = 12'(HTOT - 1);
  localparam logic [11:0] V_LAST = 12'(VTOT - 1);
  localparam logic [11:0] W_L    = 12'(W);
  localparam logic [11:0] VS_L   = 12'(VS_LINES);
  localparam logic [11:0] ACT_V0 = 12'(VS_LINES + VBP);
  localparam logic [11:0] ACT_V1 = 12'(VS_LINES + VBP + H);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      r_state;
  logic [11:0] r_h_cnt;
  logic [11:0] r_v_cnt;
  logic        r_vs;
  logic        r_de;
  logic [7:0]  r_data;
  logic        r_frame_done;
  logic        r_underflow;

  logic w_run;
  logic w_vs;
  logic w_act;
  logic w_h_last;
  logic w_v_last;
  logic w_frame_end;

  assign w_run       = (r_state == RUN);
  assign w_vs        = w_run && (r_v_cnt < VS_L);
  assign w_act       = w_run && (r_v_cnt >= ACT_V0) && (r_v_cnt < ACT_V1) && (r_h_cnt < W_L);
  assign w_h_last    = (r_h_cnt == H_LAST);
  assign w_v_last    = (r_v_cnt == V_LAST);
  assign w_frame_end = w_run && w_h_last && w_v_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_h_cnt      <= '0;
      r_v_cnt      <= '0;
      r_vs         <= 1'b0;
      r_de         <= 1'b0;
      r_data       <= 8'h00;
      r_frame_done <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      r_vs         <= w_vs;
      r_de         <= w_act;
      r_data       <= (w_act && bus.s_valid) ? bus.s_data : 8'h00;
      r_frame_done <= w_frame_end;
      if (w_act && !bus.s_valid) begin
        r_underflow <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (bus.enable) begin
            r_state <= RUN;
            r_h_cnt <= '0;
            r_v_cnt <= '0;
          end
        end
        RUN: begin
          if (w_h_last) begin
            r_h_cnt <= '0;
            if (w_v_last) begin
              // enable only matters here, so a frame always runs to completion
              r_v_cnt <= '0;
              if (!bus.enable) begin
                r_state <= IDLE;
              end
            end else begin
              r_v_cnt <= r_v_cnt + 12'd1;
            end
          end else begin
            r_h_cnt <= r_h_cnt + 12'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.s_ready    = w_act;
  assign bus.vs         = r_vs;
  assign bus.de         = r_de;
  assign bus.data       = r_data;
  assign bus.frame_done = r_frame_done;
  assign bus.underflow  = r_underflow;

endmodule

// File: tb/tb_video_stream_tx.sv
// Directed bench for video_stream_tx with a 6x6-cycle raster (W=4 H=3 HBLANK=2 VS=1 VBP=1 VFP=1).
module tb_video_stream_tx;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  video_stream_tx_if bus();

  video_stream_tx #(
    .W(4), .H(3), .HBLANK(2), .VS_LINES(1), .VBP(1), .VFP(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int pix;
  int consumed;

  logic       vs_a  [0:128];
  logic       de_a  [0:128];
  logic       fd_a  [0:128];
  logic       uf_a  [0:128];
  logic       rdy_a [0:128];
  logic [7:0] dat_a [0:128];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: inputs already set; record outputs of edge k at the following negedge.
  task automatic cyc(input int k);
    logic rdy;
    rdy = bus.s_ready;
    @(posedge clk);
    if (rdy) begin
      consumed++;
      pix++;
    end
    @(negedge clk);
    bus.s_data = 8'(pix);
    vs_a[k]  = bus.vs;
    de_a[k]  = bus.de;
    fd_a[k]  = bus.frame_done;
    uf_a[k]  = bus.underflow;
    rdy_a[k] = rdy;
    dat_a[k] = bus.data;
  endtask

  function automatic int cnt(input int sel, input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) begin
      case (sel)
        0:       if (vs_a[i])  n++;
        1:       if (de_a[i])  n++;
        2:       if (fd_a[i])  n++;
        default: if (rdy_a[i]) n++;
      endcase
    end
    return n;
  endfunction

  task automatic restart();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pix = 0;
    consumed = 0;
    bus.s_data = 8'h00;
    bus.s_valid = 1'b1;
    bus.enable = 1'b1;
    cyc(0);
  endtask

  initial begin
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data = 8'h00;
    pix = 0;
    consumed = 0;
    #1;
    check("rst_vs", bus.vs, 0);
    check("rst_de", bus.de, 0);
    check("rst_data", bus.data, 0);
    check("rst_fd", bus.frame_done, 0);
    check("rst_uf", bus.underflow, 0);
    check("rst_rdy", bus.s_ready, 0);

    // Basic frame, back-to-back second frame, graceful stop in the third
    restart();
    for (int k = 1; k <= 108; k++) begin
      if (k == 82) bus.enable = 1'b0;
      cyc(k);
    end
    for (int k = 109; k <= 128; k++) cyc(k);

    check("vs_first", vs_a[1], 1);
    check("vs_cnt", cnt(0, 1, 36), 6);
    check("vs_fall", vs_a[7], 0);
    check("de_pre", de_a[12], 0);
    check("de_start0", de_a[13], 1);
    check("dat13", dat_a[13], 0);
    check("dat16", dat_a[16], 3);
    check("de_blank", de_a[17], 0);
    check("de_start1", de_a[19], 1);
    check("dat19", dat_a[19], 4);
    check("de_start2", de_a[25], 1);
    check("dat25", dat_a[25], 8);
    check("dat28", dat_a[28], 11);
    check("de_cnt", cnt(1, 1, 36), 12);
    check("fd36", fd_a[36], 1);
    check("fd_cnt", cnt(2, 1, 36), 1);
    check("uf_clean", uf_a[36], 0);
    check("vs36", vs_a[36], 0);
    check("vs_rise2", vs_a[37], 1);
    check("dat49", dat_a[49], 12);
    check("rdy_cnt2", cnt(3, 1, 72), 24);
    check("stop_de", cnt(1, 73, 108), 12);
    check("stop_fd", fd_a[108], 1);
    check("idle_vs", cnt(0, 109, 128), 0);
    check("idle_de", cnt(1, 109, 128), 0);
    check("idle_rdy", cnt(3, 109, 128), 0);

    // Underflow on 2nd pixel of first active line
    restart();
    for (int k = 1; k <= 72; k++) begin
      bus.s_valid = (k != 14);
      cyc(k);
    end
    check("uf_de", de_a[14], 1);
    check("uf_dat", dat_a[14], 0);
    check("uf_before", uf_a[13], 0);
    check("uf_rise", uf_a[14], 1);
    check("uf_dat15", dat_a[15], 2);
    check("uf_sticky", uf_a[72], 1);

    // Asynchronous reset in the 2nd active line, then full restart
    restart();
    for (int k = 1; k <= 20; k++) cyc(k);
    check("mid_de", de_a[20], 1);
    check("mid_dat", dat_a[20], 5);
    #2;
    rst = 1'b1;
    #1;
    check("arst_vs", bus.vs, 0);
    check("arst_de", bus.de, 0);
    check("arst_data", bus.data, 0);
    check("arst_rdy", bus.s_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    pix = 0;
    consumed = 0;
    bus.s_data = 8'h00;
    cyc(0);
    for (int k = 1; k <= 36; k++) cyc(k);
    check("rs_vs1", vs_a[1], 1);
    check("rs_vs_cnt", cnt(0, 1, 36), 6);
    check("rs_de13", de_a[13], 1);
    check("rs_dat14", dat_a[14], 1);
    check("rs_de_cnt", cnt(1, 1, 36), 12);
    check("rs_fd36", fd_a[36], 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/video_stream_tx.md
VIDEO_STREAM_TX -- requirements
Module: video_stream_tx

Interface
REQ-001 Parameter W, default 640, active pixels per line.
REQ-002 Parameter H, default 480, active lines per frame.
REQ-003 Parameter HBLANK, default 160, blank cycles after the active pixels of each line (>=1).
REQ-004 Parameter VS_LINES, default 2, lines with vs high at frame start (>=1).
REQ-005 Parameters VBP and VFP, default 33 and 10, blank lines before and after the active lines (>=0).
REQ-006 Line and frame totals SHALL each be <= 4095; all counters are 12 bits wide.
REQ-007 Ports SHALL be, one per line:
 clk  in  1  single clock, rising edge.
 rst  in  1  reset, asynchronous and active-high.
 enable  in  1  run request.
 s_valid  in  1  upstream pixel valid.
 s_data  in  8  upstream pixel (Bayer raw).
 s_ready  out  1  pixel accepted this cycle.
 vs  out  1  frame sync, active-high.
 de  out  1  data enable, active-high.
 data  out  8  pixel aligned with de.
 frame_done  out  1  one-cycle pulse at frame end.
 underflow  out  1  sticky flag: pixel requested but not valid.

Function
REQ-008 The block SHALL be a two-state FSM: IDLE and RUN.
REQ-009 IDLE SHALL go to RUN on the first edge with enable=1, with h_cnt=0 and v_cnt=0 on the following cycle.
REQ-010 In RUN, h_cnt SHALL count 0..W+HBLANK-1 and wrap to 0. v_cnt SHALL increment on each h_cnt wrap and count 0..VS_LINES+VBP+H+VFP-1.
REQ-011 At the last cycle of a frame (both counters at max), the FSM SHALL:
 - wrap to a new frame (counters 0) if enable=1;
 - otherwise go to IDLE.
 enable is sampled only at that point, so a frame is never truncated.
REQ-012 Internal timing terms:
 - vs_i = RUN and v_cnt < VS_LINES.
 - act_i = RUN and VS_LINES+VBP <= v_cnt < VS_LINES+VBP+H and h_cnt < W.
REQ-013 s_ready SHALL equal act_i combinationally. A pixel is consumed when s_ready=1, whether or not s_valid=1.
REQ-014 vs and de SHALL be the registered vs_i and act_i (latency 1 cycle).
REQ-015 data SHALL be the registered value of:
 - s_data when act_i and s_valid;
 - 8'h00 when act_i and !s_valid;
 - 8'h00 when de=0.
REQ-016 underflow SHALL set on any cycle with act_i=1 and s_valid=0, and remain set until rst.
REQ-017 frame_done SHALL pulse for 1 cycle, registered from the last cycle of the frame, so it coincides with the last registered vs/de sample.
REQ-018 Output stream SHALL be exactly H de-bursts of exactly W cycles per frame, each burst followed by HBLANK de=0 cycles. vs SHALL fall exactly once per frame, at v_cnt=VS_LINES line start (+1 cycle).
REQ-019 s_valid without s_ready SHALL be ignored (no buffering in this block).

Reset
REQ-020 While rst=1, regardless of clk:
 - FSM = IDLE; h_cnt = v_cnt = 0;
 - vs = de = frame_done = underflow = 0; data = 8'h00; s_ready = 0.
REQ-021 rst asserted mid-frame SHALL abort the frame immediately. After release, the block SHALL restart from v_cnt=0 only via REQ-009.

Verification
(Unless stated, W=4, H=3, HBLANK=2, VS_LINES=1, VBP=1, VFP=1: line = 6 cycles, frame = 36 cycles.)
REQ-022 Basic frame: enable held 1, s_valid=1, s_data incrementing from 0 -> vs high for 6 cycles; then de bursts of 4 carrying 0..3, 4..7, 8..11, starting at output cycles 13, 19, 25; frame_done at output cycle 36; underflow=0.
REQ-023 Back-to-back: enable stays 1 for 2 frames -> second vs rise exactly 36 cycles after the first; no idle gap; s_ready count = 24.
REQ-024 Graceful stop: enable drops at cycle 10 of a frame -> frame completes (12 de cycles, frame_done pulses); then vs = de = 0 permanently; s_ready stays 0.
REQ-025 Underflow: s_valid=0 on the 2nd pixel of line 1 -> data=8'h00 with de=1 that cycle; underflow rises 1 cycle later and stays set through subsequent frames.
REQ-026 Reset mid-frame: rst pulsed during the 2nd active line -> vs, de, data, s_ready = 0 asynchronously; with enable=1 after release, a full 36-cycle frame restarts from vs high.
REQ-027 Default parameters: one frame with s_valid=1 -> 480 de bursts of exactly 640 cycles and 307200 pixels consumed.
